distance_digit_formatter: RTL and testbench

Converts raw ultrasonic range samples into three ASCII character codes for the on-screen distance overlay. It sits between the distance meter, which produces 9-bit centimetre values, and the distance character ROM, which looks up glyphs by 7-bit char code. It smooths samples with a running average over a power-of-two window, then performs a sequential shift-add-3 (double-dabble) binary-to-BCD conversion. Digits are presented with leading-zero blanking and an out-of-range indication. It runs in the VGA pixel clock domain.

---
 rtl/distance_digit_formatter.sv | 131 +++++++++++++
 tb/tb_distance_digit_formatter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/distance_digit_formatter.sv
// Running-average range smoother with sequential double-dabble BCD conversion,
// producing three ASCII char codes for the distance overlay.
module distance_digit_formatter #(
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned MAX_CM     = 400,
    parameter int unsigned LEAD_BLANK = 1
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [8:0] distance_cm,
    input  logic       distance_valid,
    output logic       busy,
    output logic [6:0] char_hundreds,
    output logic [6:0] char_tens,
    output logic [6:0] char_ones,
    output logic       out_of_range,
    output logic       digits_valid
);
    localparam int unsigned SUM_W = 9 + AVG_LOG2;
    localparam int unsigned PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned BUF_N = 1 << PTR_W;

    typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

    state_t             state;
    logic [8:0]         buf_mem [BUF_N];
    logic [SUM_W-1:0]   sum;
    logic [PTR_W-1:0]   wr_ptr;
    logic               first;
    logic [8:0]         bin;
    logic [11:0]        bcd;
    logic [3:0]         iter;
    logic               oor_next;

    logic [8:0]         avg;
    logic [11:0]        bcd_adj;
    logic [6:0]         fmt_h, fmt_t, fmt_o;

    assign avg = 9'(sum >> AVG_LOG2);

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Final char codes from the converted BCD value.
    always_comb begin
        fmt_h = 7'h30 + 7'(bcd[11:8]);
        fmt_t = 7'h30 + 7'(bcd[7:4]);
        fmt_o = 7'h30 + 7'(bcd[3:0]);
        if (oor_next) begin
            fmt_h = 7'h2D;
            fmt_t = 7'h2D;
            fmt_o = 7'h2D;
        end else if (LEAD_BLANK != 0 && bcd[11:8] == 4'd0) begin
            fmt_h = 7'h20;
            if (bcd[7:4] == 4'd0)
                fmt_t = 7'h20;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            digits_valid  <= 1'b0;
            out_of_range  <= 1'b0;
            char_hundreds <= 7'h20;
            char_tens     <= 7'h20;
            char_ones     <= 7'h30;
            for (int i = 0; i < BUF_N; i++)
                buf_mem[i] <= '0;
            sum           <= '0;
            wr_ptr        <= '0;
            first         <= 1'b1;
            bin           <= '0;
            bcd           <= '0;
            iter          <= '0;
            oor_next      <= 1'b0;
        end else begin
            digits_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (distance_valid) begin
                        // First sample fills the whole window so no stale zeros are averaged in.
                        if (first) begin
                            for (int i = 0; i < BUF_N; i++)
                                buf_mem[i] <= distance_cm;
                            sum   <= SUM_W'(distance_cm) << AVG_LOG2;
                            first <= 1'b0;
                        end else begin
                            buf_mem[wr_ptr] <= distance_cm;
                            sum <= sum - SUM_W'(buf_mem[wr_ptr]) + SUM_W'(distance_cm);
                        end
                        wr_ptr <= (AVG_LOG2 == 0) ? '0 : wr_ptr + PTR_W'(1);
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    bin      <= avg;
                    bcd      <= '0;
                    oor_next <= (32'(avg) > 32'(MAX_CM));
                    iter     <= '0;
                    state    <= CONV;
                end
                CONV: begin
                    bcd  <= {bcd_adj[10:0], bin[8]};
                    bin  <= {bin[7:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd8)
                        state <= DONE;
                end
                DONE: begin
                    char_hundreds <= fmt_h;
                    char_tens     <= fmt_t;
                    char_ones     <= fmt_o;
                    out_of_range  <= oor_next;
                    digits_valid  <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_distance_digit_formatter.sv
// Bench for distance_digit_formatter: directed scenarios plus randomized
// samples checked against a window-average / decimal-digit reference model.
module tb_distance_digit_formatter;
    localparam int unsigned WIN = 4;
    localparam int unsigned MAXC = 400;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] distance_cm = '0;
    logic       distance_valid = 1'b0;
    logic       busy;
    logic [6:0] char_hundreds, char_tens, char_ones;
    logic       out_of_range, digits_valid;

    distance_digit_formatter dut (
        .pclk(pclk), .rst(rst), .distance_cm(distance_cm),
        .distance_valid(distance_valid), .busy(busy),
        .char_hundreds(char_hundreds), .char_tens(char_tens),
        .char_ones(char_ones), .out_of_range(out_of_range),
        .digits_valid(digits_valid)
    );

    always #20 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    int hist[$];
    logic [6:0] exp_h = 7'h20, exp_t = 7'h20, exp_o = 7'h30;
    logic       exp_oor = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic model_reset();
        hist.delete();
        exp_h = 7'h20; exp_t = 7'h20; exp_o = 7'h30; exp_oor = 1'b0;
    endtask

    // Reference: mean of the last WIN accepted samples, then decimal split.
    task automatic model_accept(input int v);
        int total, a, h, t, o;
        if (hist.size() == 0)
            for (int i = 0; i < WIN; i++) hist.push_back(v);
        else begin
            hist.push_back(v);
            void'(hist.pop_front());
        end
        total = 0;
        foreach (hist[i]) total += hist[i];
        a = total / WIN;
        exp_oor = (a > MAXC);
        h = a / 100; t = (a / 10) % 10; o = a % 10;
        if (exp_oor) begin
            exp_h = 7'h2D; exp_t = 7'h2D; exp_o = 7'h2D;
        end else begin
            exp_h = (h == 0) ? 7'h20 : 7'(8'h30 + h);
            exp_t = (h == 0 && t == 0) ? 7'h20 : 7'(8'h30 + t);
            exp_o = 7'(8'h30 + o);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_h"}, 32'(char_hundreds), 32'(exp_h));
        check_eq({tag, "_t"}, 32'(char_tens), 32'(exp_t));
        check_eq({tag, "_o"}, 32'(char_ones), 32'(exp_o));
        check_eq({tag, "_oor"}, 32'(out_of_range), 32'(exp_oor));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        distance_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_dv", 32'(digits_valid), 32'd0);
        check_outputs("rst");
    endtask

    // Strobe v in cycle 0; optionally strobe drop_v (which must be ignored) in drop_cyc.
    task automatic send(input int v, input int drop_cyc, input int drop_v);
        logic [6:0] ph, pt, po;
        logic       poor;
        ph = exp_h; pt = exp_t; po = exp_o; poor = exp_oor;
        distance_cm = 9'(v);
        distance_valid = 1'b1;
        tick();
        distance_valid = 1'b0;
        model_accept(v);
        for (int c = 1; c <= 11; c++) begin
            if (c == drop_cyc) begin
                distance_cm = 9'(drop_v);
                distance_valid = 1'b1;
            end
            check_eq("busy_conv", 32'(busy), 32'd1);
            check_eq("dv_early", 32'(digits_valid), 32'd0);
            check_eq("hold_h", 32'(char_hundreds), 32'(ph));
            check_eq("hold_o", 32'(char_ones), 32'(po));
            check_eq("hold_oor", 32'(out_of_range), 32'(poor));
            check_eq("hold_t", 32'(char_tens), 32'(pt));
            tick();
            distance_valid = 1'b0;
        end
        check_eq("dv_pulse", 32'(digits_valid), 32'd1);
        check_eq("busy_done", 32'(busy), 32'd0);
        check_outputs("result");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("dv_idle", 32'(digits_valid), 32'd0);
        end
    endtask

    initial begin
        #1;
        do_reset();

        // First sample, then averaging toward 100.
        send(123, 0, 0);
        for (int k = 0; k < 4; k++) begin
            idle(k);
            send(100, 0, 0);
        end
        check_eq("avg_final_t", 32'(char_tens), 32'h30);

        // Range limits.
        do_reset(); send(450, 0, 0);
        check_eq("oor_450", 32'(out_of_range), 32'd1);
        do_reset(); send(511, 0, 0);
        do_reset(); send(400, 0, 0);
        check_eq("max_h", 32'(char_hundreds), 32'h34);

        // Blanking.
        do_reset(); send(7, 0, 0);
        do_reset(); send(0, 0, 0);
        do_reset(); send(40, 0, 0);
        check_eq("blank40_t", 32'(char_tens), 32'h34);

        // Dropped strobe while busy; follow-up sample proves the sum excluded it.
        do_reset(); send(200, 5, 300);
        idle(3);
        send(100, 0, 0);
        check_eq("drop_avg_t", 32'(char_tens), 32'h37);

        // Abort by reset mid-conversion.
        do_reset();
        distance_cm = 9'd250;
        distance_valid = 1'b1;
        tick();
        distance_valid = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_outputs("abort");
        idle(15);
        check_outputs("abort_hold");
        send(90, 0, 0);
        check_eq("abort90_h", 32'(char_hundreds), 32'h20);

        // Randomized samples with random gaps, drops and resets.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            int v, dc;
            if ($urandom_range(0, 9) == 0) do_reset();
            case ($urandom_range(0, 3))
                0: v = $urandom_range(380, 420);
                1: v = $urandom_range(0, 20);
                default: v = $urandom_range(0, 511);
            endcase
            dc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 11) : 0;
            send(v, dc, $urandom_range(0, 511));
            idle($urandom_range(0, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
